dm_bus_arbiter: RTL and testbench
=================================

// Module: dm_bus_arbiter
// PURPOSE
//  Two-master arbiter and sequencer for the shared single-port data memory of the pipelined MIPS SoC.
//  Master 0 is the CPU MEM-stage data port; master 1 is the UART loader / DMA port.
//  Grants one access at a time with round-robin priority and runs the fixed-latency memory handshake.
//  Returns read data plus a one-cycle ack. Drives a stall signal back to the CPU pipeline.
// PARAMETERS
//  ADDR_W   12  word-address width of data memory (byte range 0 .. 4*2^ADDR_W-1)
//  MEM_LAT  2   cycles from the mem_en cycle to valid mem_rdata; legal range >=1
// PORTS
//  clk        in   1       single system clock; all logic on rising edge
//  reset      in   1       synchronous, active-low reset
//  mN_req     in   1       access request, N=0,1; held high until mN_ack
//  mN_we      in   1       1=write, 0=read
//  mN_be      in   4       byte enables for writes
//  mN_addr    in   32      byte address; bits [1:0] ignored
//  mN_wdata   in   32      write data
//  mN_ack     out  1       one-cycle completion pulse
//  mN_err     out  1       pulses with mN_ack when the address is out of range
//  mN_rdata   out  32      read data; valid in the mN_ack cycle
//  mem_en     out  1       memory command strobe, exactly one cycle per access
//  mem_we     out  4       byte write strobes; 4'b0000 for reads
//  mem_addr   out  ADDR_W  word address = latched addr[ADDR_W+1:2]
//  mem_wdata  out  32      latched write data
//  mem_rdata  in   32      memory read data, valid MEM_LAT cycles after mem_en
//  cpu_stall  out  1       m0_req & ~m0_ack
//  busy       out  1       state != IDLE
// BEHAVIOUR
//  Reset (reset==0 at an edge), also mid-transaction:
//   - state=IDLE, last_grant=1 so M0 wins the first tie, lat counter=0.
//   - mem_en=0, mem_we=0, both acks/errs=0, rdata regs=0, busy=0.
//   - The in-flight access is abandoned; no ack is ever issued for it.
//  FSM IDLE -> BUSY -> DONE -> IDLE:
//   - IDLE: if no req, stay. One req: grant it. Both: grant the master != last_grant.
//     On grant, latch owner, we, be, addr, wdata; update last_grant.
//     In-range address -> BUSY. addr[31:ADDR_W+2] != 0 -> DONE with err flagged; no memory access.
//   - BUSY: first BUSY cycle drives mem_en=1 and mem_we=(we ? be : 0); both are 0 on all other cycles.
//     Counter counts MEM_LAT cycles. In the cycle where mem_rdata is valid, capture it if a read, then go DONE.
//   - DONE: owner's ack=1 for exactly one cycle, plus err if flagged. rdata reg holds captured data
//     (0 on error; previous value on a write). The non-owner's ack stays 0. Next state IDLE.
//  Latency: req sampled in IDLE at cycle 0 -> mem_en at cycle 1 -> ack at cycle MEM_LAT+2.
//   Error path: ack at cycle 2. The arbiter accepts a new grant every MEM_LAT+3 cycles at most.
//  Requester rules:
//   - req must be low in the cycle after ack; a req high in IDLE is always a new request.
//   - A req dropped before ack is ignored; the latched access completes and ack still pulses.
//   - A master's request inputs may change after the grant; the latched values are used.
//  Simultaneous events:
//   - A request arriving while BUSY/DONE waits and is evaluated in the next IDLE.
//   - Back-to-back contention alternates strictly M0, M1, M0, ...
//   - A lone requester is granted every time regardless of last_grant.
//  Width rules: counter width is $clog2(MEM_LAT+1); address truncation as above; no byte-lane shifting.
// STRUCTURE
//  Shared package dm_bus_pkg:
//   - state encoding localparams S_IDLE=2'd0, S_BUSY=2'd1, S_DONE=2'd2.
//   - DM_BE_NONE=4'b0000.
//  Sub-module rr_arb2: combinational 2-way round-robin pick (req[1:0], last -> gnt[1:0]), reused by the future MMIO bridge.
//  All outputs except cpu_stall and busy are registered or derived from registered state only.
// TESTING
//  1. MEM_LAT=2. M0 reads 0x0000_0010 (mem word 4 = 0xDEADBEEF) -> mem_en at cycle 1 with mem_addr=4;
//     m0_ack and m0_rdata=0xDEADBEEF at cycle 4; cpu_stall high for cycles 0-3.
//  2. M1 writes 0x0000_0008 with be=4'b0011, wdata=0x1234_5678 -> mem_we=4'b0011, mem_addr=2 for exactly one cycle;
//     m1_ack at cycle 4; m0_ack stays 0.
//  3. Both req continuously after reset -> grant order M0, M1, M0, M1; acks spaced 5 cycles apart; no ack overlap.
//  4. M0 reads 0x0001_0000 with ADDR_W=12 -> no mem_en; m0_ack=m0_err=1 at cycle 2; m0_rdata=0.
//  5. Drop reset to 0 during BUSY -> next cycle busy=0, mem_en=0, no ack. After release, a tie grants M0 first.
//  6. MEM_LAT=1 and MEM_LAT=4 rerun of scenario 1 -> ack at cycle 3 and cycle 6 respectively.

Source files
------------

// File: rtl/dm_bus_pkg.sv
// Shared types and constants for the data-memory bus arbiter.
package dm_bus_pkg;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   localparam logic [3:0] DM_BE_NONE = 4'b0000;

endpackage

// File: rtl/dm_bus_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick: on a tie the master that was
// not granted last wins; a lone requester always wins.
module rr_arb2
   import dm_bus_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   // Grant selection from current requests and the last winner.
   always_comb begin
      gnt    = 2'b00;
      gnt[0] = req[0] & (~req[1] | last);
      gnt[1] = req[1] & (~req[0] | ~last);
   end

endmodule

// File: rtl/dm_bus_arbiter.sv
// Two-master arbiter and sequencer for the shared single-port data memory.
// Master 0 is the CPU MEM-stage port, master 1 the UART loader / DMA port.
module dm_bus_arbiter
   import dm_bus_pkg::*;
#(
   parameter int unsigned ADDR_W  = 12,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              m0_req,
   input  logic              m0_we,
   input  logic [3:0]        m0_be,
   input  logic [31:0]       m0_addr,
   input  logic [31:0]       m0_wdata,
   output logic              m0_ack,
   output logic              m0_err,
   output logic [31:0]       m0_rdata,
   input  logic              m1_req,
   input  logic              m1_we,
   input  logic [3:0]        m1_be,
   input  logic [31:0]       m1_addr,
   input  logic [31:0]       m1_wdata,
   output logic              m1_ack,
   output logic              m1_err,
   output logic [31:0]       m1_rdata,
   output logic              mem_en,
   output logic [3:0]        mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [31:0]       mem_wdata,
   input  logic [31:0]       mem_rdata,
   output logic              cpu_stall,
   output logic              busy
);

   localparam int unsigned      CNT_W    = $clog2(MEM_LAT + 1);
   localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(MEM_LAT);

   state_t           state;
   state_t           state_nx;
   logic             last_grant;
   logic             owner;
   logic             lat_we;
   logic             err_flag;
   logic [CNT_W-1:0] lat_cnt;
   logic             lat_done;
   logic [1:0]       gnt;
   logic             gnt_any;
   logic             gnt_we;
   logic [3:0]       gnt_be;
   logic [31:0]      gnt_addr;
   logic [31:0]      gnt_wdata;
   logic             gnt_oor;
   logic             unused_addr_lsbs;

   rr_arb2 u_rr_arb2 (
      .req  ({m1_req, m0_req}),
      .last (last_grant),
      .gnt  (gnt)
   );

   // Mux the winning master's request fields and classify its address.
   always_comb begin
      gnt_any   = |gnt;
      gnt_we    = gnt[1] ? m1_we    : m0_we;
      gnt_be    = gnt[1] ? m1_be    : m0_be;
      gnt_addr  = gnt[1] ? m1_addr  : m0_addr;
      gnt_wdata = gnt[1] ? m1_wdata : m0_wdata;
      gnt_oor   = |gnt_addr[31:ADDR_W+2];
      lat_done  = (lat_cnt == LAT_LAST);
      unused_addr_lsbs = ^gnt_addr[1:0];
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nx;
   end

   // Next-state logic. An out-of-range access still spends one BUSY cycle
   // (with mem_en suppressed) so its ack lands two cycles after the grant.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE:  if (gnt_any) state_nx = S_BUSY;
         S_BUSY:  if (err_flag || lat_done) state_nx = S_DONE;
         S_DONE:  state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // Grant latch, memory command, latency counter, ack/err and read data.
   always_ff @(posedge clk) begin
      if (!reset) begin
         last_grant <= 1'b1;
         owner      <= 1'b0;
         lat_we     <= 1'b0;
         err_flag   <= 1'b0;
         lat_cnt    <= '0;
         mem_en     <= 1'b0;
         mem_we     <= DM_BE_NONE;
         mem_addr   <= '0;
         mem_wdata  <= '0;
         m0_ack     <= 1'b0;
         m0_err     <= 1'b0;
         m0_rdata   <= '0;
         m1_ack     <= 1'b0;
         m1_err     <= 1'b0;
         m1_rdata   <= '0;
      end else begin
         mem_en <= 1'b0;
         mem_we <= DM_BE_NONE;
         m0_ack <= 1'b0;
         m0_err <= 1'b0;
         m1_ack <= 1'b0;
         m1_err <= 1'b0;
         case (state)
            S_IDLE: begin
               if (gnt_any) begin
                  owner      <= gnt[1];
                  last_grant <= gnt[1];
                  lat_we     <= gnt_we;
                  err_flag   <= gnt_oor;
                  lat_cnt    <= '0;
                  mem_addr   <= gnt_addr[ADDR_W+1:2];
                  mem_wdata  <= gnt_wdata;
                  mem_en     <= ~gnt_oor;
                  mem_we     <= (!gnt_oor && gnt_we) ? gnt_be : DM_BE_NONE;
               end
            end
            S_BUSY: begin
               if (err_flag) begin
                  if (owner) begin
                     m1_ack   <= 1'b1;
                     m1_err   <= 1'b1;
                     m1_rdata <= '0;
                  end else begin
                     m0_ack   <= 1'b1;
                     m0_err   <= 1'b1;
                     m0_rdata <= '0;
                  end
               end else if (lat_done) begin
                  lat_cnt <= '0;
                  if (owner) begin
                     m1_ack <= 1'b1;
                     if (!lat_we) m1_rdata <= mem_rdata;
                  end else begin
                     m0_ack <= 1'b1;
                     if (!lat_we) m0_rdata <= mem_rdata;
                  end
               end else begin
                  lat_cnt <= lat_cnt + CNT_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign cpu_stall = m0_req & ~m0_ack;
   assign busy      = (state != S_IDLE);

endmodule

// File: tb/tb_dm_bus_arbiter.sv
// Self-checking bench for dm_bus_arbiter: vector table plus hand sequences,
// with ack and memory-command scoreboards checked by a negedge monitor.
module tb_dm_bus_arbiter;

   localparam int LAT = 2;

   typedef struct {
      int          m;
      logic        err;
      logic [31:0] rdata;
      int          cyc;
   } ack_exp_t;

   typedef struct {
      logic [11:0] addr;
      logic [3:0]  we;
      logic [31:0] wdata;
      int          cyc;
   } mem_exp_t;

   typedef struct {
      int          m;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        err;
      logic [31:0] rdata;
   } vec_t;

   logic clk = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   failures = 0;
   int   acks_seen = 0;

   logic        m0_req = 1'b0, m0_we = 1'b0, m1_req = 1'b0, m1_we = 1'b0;
   logic [3:0]  m0_be = '0, m1_be = '0;
   logic [31:0] m0_addr = '0, m0_wdata = '0, m1_addr = '0, m1_wdata = '0;
   logic        m0_ack, m0_err, m1_ack, m1_err, cpu_stall, busy;
   logic [31:0] m0_rdata, m1_rdata;

   logic        mem_en_v [3];
   logic [3:0]  mem_we_v [3];
   logic [11:0] mem_addr_v [3];
   logic [31:0] mem_wdata_v [3];
   logic [31:0] mem_rdata_v [3];

   logic        zero1 = 1'b0;
   logic [3:0]  zero4 = '0;
   logic [31:0] zero32 = '0;
   logic [1:0]  x_req = '0;
   logic [31:0] x_addr [2];
   logic [1:0]  x_m0ack, x_m0err, x_m1ack, x_m1err, x_stall, x_busy;
   logic [31:0] x_m0rd [2];
   logic [31:0] x_m1rd [2];

   ack_exp_t ackq [$];
   mem_exp_t memq [$];
   vec_t     vecs [10];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   dm_bus_arbiter #(.ADDR_W(12), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset),
      .m0_req(m0_req), .m0_we(m0_we), .m0_be(m0_be), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_we(m1_we), .m1_be(m1_be), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
      .mem_en(mem_en_v[0]), .mem_we(mem_we_v[0]), .mem_addr(mem_addr_v[0]),
      .mem_wdata(mem_wdata_v[0]), .mem_rdata(mem_rdata_v[0]),
      .cpu_stall(cpu_stall), .busy(busy)
   );

   dm_bus_arbiter #(.ADDR_W(12), .MEM_LAT(1)) u_dut_lat1 (
      .clk(clk), .reset(reset),
      .m0_req(x_req[0]), .m0_we(zero1), .m0_be(zero4), .m0_addr(x_addr[0]), .m0_wdata(zero32),
      .m0_ack(x_m0ack[0]), .m0_err(x_m0err[0]), .m0_rdata(x_m0rd[0]),
      .m1_req(zero1), .m1_we(zero1), .m1_be(zero4), .m1_addr(zero32), .m1_wdata(zero32),
      .m1_ack(x_m1ack[0]), .m1_err(x_m1err[0]), .m1_rdata(x_m1rd[0]),
      .mem_en(mem_en_v[1]), .mem_we(mem_we_v[1]), .mem_addr(mem_addr_v[1]),
      .mem_wdata(mem_wdata_v[1]), .mem_rdata(mem_rdata_v[1]),
      .cpu_stall(x_stall[0]), .busy(x_busy[0])
   );

   dm_bus_arbiter #(.ADDR_W(12), .MEM_LAT(4)) u_dut_lat4 (
      .clk(clk), .reset(reset),
      .m0_req(x_req[1]), .m0_we(zero1), .m0_be(zero4), .m0_addr(x_addr[1]), .m0_wdata(zero32),
      .m0_ack(x_m0ack[1]), .m0_err(x_m0err[1]), .m0_rdata(x_m0rd[1]),
      .m1_req(zero1), .m1_we(zero1), .m1_be(zero4), .m1_addr(zero32), .m1_wdata(zero32),
      .m1_ack(x_m1ack[1]), .m1_err(x_m1err[1]), .m1_rdata(x_m1rd[1]),
      .mem_en(mem_en_v[2]), .mem_we(mem_we_v[2]), .mem_addr(mem_addr_v[2]),
      .mem_wdata(mem_wdata_v[2]), .mem_rdata(mem_rdata_v[2]),
      .cpu_stall(x_stall[1]), .busy(x_busy[1])
   );

   // Memory model: initial contents come from pre_word, writes land in an overlay.
   function automatic logic [31:0] pre_word(input logic [11:0] a);
      case (a)
         12'd2:   return 32'hA5A5_A5A5;
         12'd4:   return 32'hDEAD_BEEF;
         12'd5:   return 32'h5555_5555;
         default: return {16'hC0DE, 4'h0, a};
      endcase
   endfunction

   bit   [31:0] wmem [4096];
   bit          wval [4096];
   logic [3:0]  pv [3];
   logic [11:0] pa [3][4];
   logic [31:0] cur;

   initial for (int i = 0; i < 3; i++) pv[i] = '0;

   always @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         pv[i]    <= {pv[i][2:0], mem_en_v[i]};
         pa[i][0] <= mem_addr_v[i];
         for (int k = 1; k < 4; k++) pa[i][k] <= pa[i][k-1];
      end
      if (mem_en_v[0] && mem_we_v[0] != 4'h0) begin
         cur = wval[mem_addr_v[0]] ? wmem[mem_addr_v[0]] : pre_word(mem_addr_v[0]);
         for (int b = 0; b < 4; b++)
            if (mem_we_v[0][b]) cur[8*b +: 8] = mem_wdata_v[0][8*b +: 8];
         wmem[mem_addr_v[0]] <= cur;
         wval[mem_addr_v[0]] <= 1'b1;
      end
   end

   // Read data is only meaningful in the cycle MEM_LAT after mem_en.
   assign mem_rdata_v[0] = pv[0][1] ? (wval[pa[0][1]] ? wmem[pa[0][1]] : pre_word(pa[0][1])) : 32'hBAD0_BAD0;
   assign mem_rdata_v[1] = pv[1][0] ? pre_word(pa[1][0]) : 32'hBAD0_BAD0;
   assign mem_rdata_v[2] = pv[2][3] ? pre_word(pa[2][3]) : 32'hBAD0_BAD0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%08h required=0x%08h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Scoreboard monitor for the main instance.
   ack_exp_t   ea;
   mem_exp_t   em;
   logic [3:0] ef;
   always @(negedge clk) begin
      if (m0_ack || m1_ack || m0_err || m1_err) begin
         if (ackq.size() == 0) begin
            check("unexpected_ack", {28'd0, m1_ack, m1_err, m0_ack, m0_err}, 32'd0);
         end else begin
            ea = ackq.pop_front();
            ef = (ea.m == 1) ? {1'b1, ea.err, 2'b00} : {2'b00, 1'b1, ea.err};
            check("ack_flags", {28'd0, m1_ack, m1_err, m0_ack, m0_err}, {28'd0, ef});
            check("ack_cycle", cyc, ea.cyc);
            check("ack_rdata", (ea.m == 1) ? m1_rdata : m0_rdata, ea.rdata);
            acks_seen++;
         end
      end
      if (mem_en_v[0]) begin
         if (memq.size() == 0) begin
            check("unexpected_mem_en", {20'd0, mem_addr_v[0]}, 32'hFFFF_FFFF);
         end else begin
            em = memq.pop_front();
            check("mem_addr", {20'd0, mem_addr_v[0]}, {20'd0, em.addr});
            check("mem_we", {28'd0, mem_we_v[0]}, {28'd0, em.we});
            check("mem_cycle", cyc, em.cyc);
            if (em.we != 4'h0) check("mem_wdata", mem_wdata_v[0], em.wdata);
         end
      end else if (mem_we_v[0] != 4'h0) begin
         check("mem_we_without_en", {28'd0, mem_we_v[0]}, 32'd0);
      end
   end

   task automatic wait_acks(input int n, input int budget);
      int start;
      start = acks_seen;
      for (int k = 0; k < budget; k++) begin
         @(negedge clk);
         #1;
         if (acks_seen >= start + n) break;
      end
      check("ack_count", acks_seen - start, n);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      reset = 1'b0; m0_req = 1'b0; m1_req = 1'b0; x_req = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
   endtask

   task automatic do_req(input vec_t v);
      int t0;
      @(posedge clk); #1;
      if (v.m == 0) begin
         m0_we = v.we; m0_be = v.be; m0_addr = v.addr; m0_wdata = v.wdata; m0_req = 1'b1;
      end else begin
         m1_we = v.we; m1_be = v.be; m1_addr = v.addr; m1_wdata = v.wdata; m1_req = 1'b1;
      end
      t0 = cyc;
      ackq.push_back(ack_exp_t'{v.m, v.err, v.rdata, t0 + (v.err ? 2 : LAT + 2)});
      if (!v.err) memq.push_back(mem_exp_t'{v.addr[13:2], v.we ? v.be : 4'h0, v.wdata, t0 + 1});
      // Scramble request fields after the grant; the latched copy must be used.
      @(posedge clk); #1;
      if (v.m == 0) begin
         m0_we = ~v.we; m0_be = ~v.be; m0_addr = v.addr ^ 32'h0000_3FF0; m0_wdata = ~v.wdata;
      end else begin
         m1_we = ~v.we; m1_be = ~v.be; m1_addr = v.addr ^ 32'h0000_3FF0; m1_wdata = ~v.wdata;
      end
      wait_acks(1, 20);
      @(posedge clk); #1;
      m0_req = 1'b0; m1_req = 1'b0;
   endtask

   int          t0;
   int          got;
   logic [31:0] rd;

   initial begin
      vecs[0] = vec_t'{1, 1'b1, 4'b0011, 32'h0000_0008, 32'h1234_5678, 1'b0, 32'hC0DE_0006};
      vecs[1] = vec_t'{1, 1'b0, 4'b0000, 32'h0000_0008, 32'h0,         1'b0, 32'hA5A5_5678};
      vecs[2] = vec_t'{0, 1'b0, 4'b0000, 32'h0001_0000, 32'h0,         1'b1, 32'h0};
      vecs[3] = vec_t'{0, 1'b1, 4'b1111, 32'h0000_3FFC, 32'hCAFE_F00D, 1'b0, 32'h0};
      vecs[4] = vec_t'{1, 1'b0, 4'b0000, 32'h0000_3FFF, 32'h0,         1'b0, 32'hCAFE_F00D};
      vecs[5] = vec_t'{1, 1'b0, 4'b0000, 32'h0000_4000, 32'h0,         1'b1, 32'h0};
      vecs[6] = vec_t'{0, 1'b0, 4'b0000, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
      vecs[7] = vec_t'{0, 1'b1, 4'b1111, 32'h8000_0000, 32'h0,         1'b1, 32'h0};
      vecs[8] = vec_t'{0, 1'b1, 4'b1000, 32'h0000_0014, 32'h1122_3344, 1'b0, 32'h0};
      vecs[9] = vec_t'{0, 1'b0, 4'b0000, 32'h0000_0014, 32'h0,         1'b0, 32'h1155_5555};
      x_addr[0] = '0;
      x_addr[1] = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_mem", {27'd0, mem_en_v[0], mem_we_v[0]}, 32'd0);
      check("rst_acks", {28'd0, m1_ack, m1_err, m0_ack, m0_err}, 32'd0);
      check("rst_rdata0", m0_rdata, 32'd0);
      check("rst_rdata1", m1_rdata, 32'd0);
      @(posedge clk); #1 reset = 1'b1;

      // M0 read of word 4 with cpu_stall tracking.
      @(posedge clk); #1;
      m0_we = 1'b0; m0_addr = 32'h0000_0010; m0_req = 1'b1;
      t0 = cyc;
      ackq.push_back(ack_exp_t'{0, 1'b0, 32'hDEAD_BEEF, t0 + 4});
      memq.push_back(mem_exp_t'{12'd4, 4'h0, 32'h0, t0 + 1});
      for (int k = 0; k <= 4; k++) begin
         @(negedge clk);
         check("cpu_stall", {31'd0, cpu_stall}, (k < 4) ? 32'd1 : 32'd0);
      end
      @(posedge clk); #1 m0_req = 1'b0;

      // Continuous contention after reset: M0, M1, M0, M1, five cycles apart.
      do_reset();
      @(posedge clk); #1;
      m0_we = 1'b0; m0_addr = 32'h0000_0010; m1_we = 1'b0; m1_addr = 32'h0000_0018;
      m0_req = 1'b1; m1_req = 1'b1;
      t0 = cyc;
      for (int g = 0; g < 4; g++) begin
         ackq.push_back(ack_exp_t'{g % 2, 1'b0, (g % 2 == 1) ? 32'hC0DE_0006 : 32'hDEAD_BEEF, t0 + 4 + 5 * g});
         memq.push_back(mem_exp_t'{(g % 2 == 1) ? 12'd6 : 12'd4, 4'h0, 32'h0, t0 + 1 + 5 * g});
      end
      wait_acks(4, 40);
      @(posedge clk); #1;
      m0_req = 1'b0; m1_req = 1'b0;

      // Table of single accesses.
      for (int i = 0; i < 10; i++) do_req(vecs[i]);

      // Reset in the middle of a BUSY access: abandoned, and M0 wins the next tie.
      @(posedge clk); #1;
      m0_we = 1'b0; m0_addr = 32'h0000_0010; m0_req = 1'b1;
      t0 = cyc;
      memq.push_back(mem_exp_t'{12'd4, 4'h0, 32'h0, t0 + 1});
      @(posedge clk); #1;
      reset = 1'b0; m0_req = 1'b0;
      @(posedge clk); #1 reset = 1'b1;
      @(negedge clk);
      check("midrst_busy", {31'd0, busy}, 32'd0);
      check("midrst_mem_en", {31'd0, mem_en_v[0]}, 32'd0);
      check("midrst_ack", {30'd0, m1_ack, m0_ack}, 32'd0);
      check("midrst_rdata0", m0_rdata, 32'd0);
      repeat (8) @(negedge clk);
      @(posedge clk); #1;
      m0_addr = 32'h0000_0010; m1_addr = 32'h0000_0018;
      m0_req = 1'b1; m1_req = 1'b1;
      t0 = cyc;
      ackq.push_back(ack_exp_t'{0, 1'b0, 32'hDEAD_BEEF, t0 + 4});
      memq.push_back(mem_exp_t'{12'd4, 4'h0, 32'h0, t0 + 1});
      wait_acks(1, 20);
      @(posedge clk); #1;
      m0_req = 1'b0; m1_req = 1'b0;

      // Same read on the MEM_LAT=1 and MEM_LAT=4 instances.
      for (int j = 0; j < 2; j++) begin
         @(posedge clk); #1;
         x_addr[j] = 32'h0000_0010;
         x_req[j]  = 1'b1;
         t0  = cyc;
         got = -1;
         rd  = '0;
         for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (x_m0ack[j]) begin
               got = cyc - t0;
               rd  = x_m0rd[j];
               break;
            end
         end
         check((j == 0) ? "lat1_ack_cycle" : "lat4_ack_cycle", got, (j == 0) ? 32'd3 : 32'd6);
         check((j == 0) ? "lat1_rdata" : "lat4_rdata", rd, 32'hDEAD_BEEF);
         @(posedge clk); #1 x_req[j] = 1'b0;
      end

      repeat (4) @(negedge clk);
      check("ackq_drained", ackq.size(), 32'd0);
      check("memq_drained", memq.size(), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
